escaner_display: RTL and testbench

- Time-multiplexed scanner for the digital clock's six-digit 7-segment display (HH:MM:SS).
- Takes the six packed BCD digits from the clock counters and presents one digit at a time to the display7segmentos decoder.
- Drives the matching active-low anode enable and the colon/decimal point.
- Captures a snapshot of the digits once per frame, so a frame never mixes old and new time values.

---
 rtl/escaner_display.sv | 86 ++++++++
 tb/tb_escaner_display.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/escaner_display.sv
// Time-multiplexed scanner for the HH:MM:SS seven-segment display.
// Shows one snapshot digit at a time with its active-low anode and separator point.
module escaner_display #(
  parameter int NUM_DIGITOS = 6,
  parameter int DIV_TICKS   = 50000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4*NUM_DIGITOS-1:0] digitos,
  input  logic                     habilitar,
  input  logic                     supresion_cero,
  input  logic                     parpadeo,
  output logic [3:0]               digito,
  output logic [NUM_DIGITOS-1:0]   anodo,
  output logic                     punto
);

  localparam int CW = (DIV_TICKS > 1) ? $clog2(DIV_TICKS) : 1;
  localparam int IW = $clog2(NUM_DIGITOS);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV_TICKS - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITOS - 1);

  logic [CW-1:0]            cnt;
  logic [IW-1:0]            indice;
  logic [4*NUM_DIGITOS-1:0] frame;
  logic                     carga_pendiente;
  logic                     valido;

  logic                     tick;
  logic                     fin_frame;
  logic                     cargar;
  logic [3:0]               valor;
  logic                     blanco;
  logic                     punto_idx;
  logic [NUM_DIGITOS-1:0]   uno_caliente;
  logic [3:0]               digs [2**IW];

  // Unpacked view of the snapshot; unused slots above NUM_DIGITOS read as 0.
  always_comb begin
    digs = '{default: 4'h0};
    for (int i = 0; i < NUM_DIGITOS; i++) begin
      digs[i] = frame[4*i +: 4];
    end
  end

  assign tick         = (cnt == CNT_MAX);
  assign fin_frame    = tick && (indice == IDX_MAX);
  assign cargar       = carga_pendiente || fin_frame;
  assign valor        = digs[indice];
  assign uno_caliente = NUM_DIGITOS'(1) << indice;
  assign blanco       = !valido || !habilitar ||
                        (supresion_cero && (indice == IDX_MAX) && (valor == 4'h0));
  assign punto_idx    = (32'(indice) == 32'd2) ||
                        ((NUM_DIGITOS > 4) && (32'(indice) == 32'd4));

  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of indice/frame/valido; blocking would skew the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt             <= '0;
      indice          <= '0;
      // NOTE: the snapshot is a plain register bank, so it is cleared like any
      // other state; outputs stay dark until valido proves it was loaded.
      frame           <= '0;
      carga_pendiente <= 1'b1;
      valido          <= 1'b0;
      digito          <= 4'h0;
      anodo           <= '1;
      punto           <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        indice <= (indice == IDX_MAX) ? '0 : indice + 1'b1;
      end
      if (cargar) begin
        frame           <= digitos;
        carga_pendiente <= 1'b0;
        valido          <= 1'b1;
      end
      digito <= valor;
      anodo  <= blanco ? '1 : ~uno_caliente;
      punto  <= parpadeo && habilitar && valido && punto_idx;
    end
  end

endmodule

// File: tb/tb_escaner_display.sv
// Bench for escaner_display: a DIV_TICKS=4 and a DIV_TICKS=1 instance checked
// every cycle against an edge-count model, plus directed literal expectations.
module tb_escaner_display;

  localparam int N = 6;

  typedef struct packed {
    logic [3:0]   dig;
    logic [N-1:0] an;
    logic         pt;
  } salida_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [4*N-1:0] digitos = 24'h235947;
  logic         habilitar = 1'b1;
  logic         supresion_cero = 1'b0;
  logic         parpadeo = 1'b0;

  logic [3:0]   dig_a, dig_b;
  logic [N-1:0] an_a, an_b;
  logic         pt_a, pt_b;

  int vectors = 0;
  int miscompares = 0;
  int k = 0;                 // non-reset edges since the last reset edge
  logic [4*N-1:0] mf_a = '0; // snapshot each instance should be displaying
  logic [4*N-1:0] mf_b = '0;

  escaner_display #(.NUM_DIGITOS(N), .DIV_TICKS(4)) dut_a (
    .clk(clk), .rst(rst), .digitos(digitos), .habilitar(habilitar),
    .supresion_cero(supresion_cero), .parpadeo(parpadeo),
    .digito(dig_a), .anodo(an_a), .punto(pt_a)
  );

  escaner_display #(.NUM_DIGITOS(N), .DIV_TICKS(1)) dut_b (
    .clk(clk), .rst(rst), .digitos(digitos), .habilitar(habilitar),
    .supresion_cero(supresion_cero), .parpadeo(parpadeo),
    .digito(dig_b), .anodo(an_b), .punto(pt_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at k=%0d: got %0h, expected %0h", nm, k, act, exp);
    end
  endtask

  // Output after edge number kk: edge 1 only loads; from edge 2 on the shown
  // index is floor((kk-1)/d) mod N, taken from the snapshot held before the edge.
  function automatic salida_t modelo(input int kk, input int d, input logic [4*N-1:0] mf,
                                     input logic h, input logic s, input logic p);
    salida_t o;
    int idx;
    logic [3:0] v;
    o = '{dig: 4'h0, an: '1, pt: 1'b0};
    if (kk >= 2) begin
      idx   = ((kk - 1) / d) % N;
      v     = mf[4*idx +: 4];
      o.dig = v;
      if (h && !(s && idx == N-1 && v == 4'h0)) o.an = ~(N'(1) << idx);
      o.pt  = p && h && (idx == 2 || idx == 4);
    end
    return o;
  endfunction

  always @(posedge clk) begin
    salida_t ea, eb;
    if (rst) begin
      k    = 0;
      mf_a = '0;
      mf_b = '0;
    end else begin
      k = k + 1;
    end
    ea = modelo(k, 4, mf_a, habilitar, supresion_cero, parpadeo);
    eb = modelo(k, 1, mf_b, habilitar, supresion_cero, parpadeo);
    if (!rst) begin
      if (k == 1 || k % (N*4) == 0) mf_a = digitos;
      if (k == 1 || k % N == 0)     mf_b = digitos;
    end
    #1;
    check("model dig_a", 32'(dig_a), 32'(ea.dig));
    check("model an_a",  32'(an_a),  32'(ea.an));
    check("model pt_a",  32'(pt_a),  32'(ea.pt));
    check("model dig_b", 32'(dig_b), 32'(eb.dig));
    check("model an_b",  32'(an_b),  32'(eb.an));
    check("model pt_b",  32'(pt_b),  32'(eb.pt));
  end

  task automatic wait_k(input int target);
    int n = 0;
    while (k != target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (k != target) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_k timeout: k=%0d, expected %0d", k, target);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Power-up frame of 23:59:47
    wait_k(1);
    check("first edge dark", 32'(an_a), 32'b111111);
    wait_k(2);
    check("idx0 digit", 32'(dig_a), 32'h7);
    check("idx0 anode", 32'(an_a), 32'b111110);
    check("idx0 punto", 32'(pt_a), 32'h0);
    check("fast idx1 digit", 32'(dig_b), 32'h4);
    check("fast idx1 anode", 32'(an_b), 32'b111101);
    wait_k(3);
    check("fast idx2 anode", 32'(an_b), 32'b111011);
    check("idx0 held", 32'(an_a), 32'b111110);
    wait_k(5);
    check("idx1 digit", 32'(dig_a), 32'h4);
    check("idx1 anode", 32'(an_a), 32'b111101);
    wait_k(9);
    check("idx2 digit", 32'(dig_a), 32'h9);
    check("idx2 anode", 32'(an_a), 32'b111011);

    // Mid-frame change must wait for the frame-end snapshot
    digitos = 24'h000000;
    wait_k(13);
    check("snapshot idx3", 32'(dig_a), 32'h5);
    wait_k(21);
    check("snapshot idx5", 32'(dig_a), 32'h2);
    check("idx5 anode", 32'(an_a), 32'b011111);
    wait_k(25);
    check("new frame idx0", 32'(dig_a), 32'h0);
    check("new frame anode", 32'(an_a), 32'b111110);

    // Leading-zero suppression on 09:15:00
    digitos = 24'h091500;
    supresion_cero = 1'b1;
    wait_k(65);
    check("supp idx4 digit", 32'(dig_a), 32'h9);
    check("supp idx4 anode", 32'(an_a), 32'b101111);
    wait_k(69);
    check("supp idx5 digit", 32'(dig_a), 32'h0);
    check("supp idx5 dark", 32'(an_a), 32'b111111);
    supresion_cero = 1'b0;
    wait_k(93);
    check("nosupp idx5 anode", 32'(an_a), 32'b011111);

    // Separator points and display blanking
    digitos  = 24'h235947;
    parpadeo = 1'b1;
    wait_k(105);
    check("punto idx2", 32'(pt_a), 32'h1);
    check("punto idx2 anode", 32'(an_a), 32'b111011);
    wait_k(109);
    check("punto idx3 off", 32'(pt_a), 32'h0);
    wait_k(113);
    check("punto idx4", 32'(pt_a), 32'h1);
    check("idx4 digit", 32'(dig_a), 32'h3);
    habilitar = 1'b0;
    wait_k(117);
    check("blank anode", 32'(an_a), 32'b111111);
    check("blank punto", 32'(pt_a), 32'h0);
    check("blank digit runs", 32'(dig_a), 32'h2);
    habilitar = 1'b1;

    // Reset while index 3 is lit
    wait_k(133);
    check("pre-reset idx3", 32'(an_a), 32'b110111);
    rst = 1'b1;
    @(negedge clk);
    check("reset anode", 32'(an_a), 32'b111111);
    check("reset digit", 32'(dig_a), 32'h0);
    check("reset punto", 32'(pt_a), 32'h0);
    rst = 1'b0;
    wait_k(1);
    check("restart dark", 32'(an_a), 32'b111111);
    wait_k(2);
    check("restart idx0", 32'(dig_a), 32'h7);
    wait_k(5);
    check("restart idx1", 32'(dig_a), 32'h4);
    wait_k(8);
    check("fast wrap idx1", 32'(an_b), 32'b111101);
    check("fast wrap digit", 32'(dig_b), 32'h4);

    // Randomized traffic, checked by the per-cycle model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      habilitar      = ($urandom_range(0, 7) != 0);
      supresion_cero = 1'($urandom_range(0, 1));
      parpadeo       = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        digitos = 24'($urandom);
        if ($urandom_range(0, 1) == 0) digitos[4*N-1 -: 4] = 4'h0;
      end
      rst = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
